// File: rtl/icache_refill_fsm.sv
// Instruction-cache refill controller: hit/miss sequencing, line burst fetch, fill-buffer writes, error recovery.
// Optional macro ICACHE_UNCACHED_EN adds an 'uncached' input for single-word bypass fetches.
module icache_refill_fsm #(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  localparam int WAY_W     = $clog2(WAYS),
  localparam int OFS_W     = $clog2(LINE_WORDS) + 2,
  localparam int IDX_W     = OFS_W - 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rvalid,
`ifdef ICACHE_UNCACHED_EN
  input  logic              uncached,
`endif
  input  logic [ADDR_W-1:0] addr,
  input  logic [WAYS-1:0]   hit,
  input  logic [WAY_W-1:0]  victim_way,
  input  logic              i_arready,
  input  logic              i_rvalid,
  input  logic              i_rlast,
  output logic              rready,
  output logic              i_arvalid,
  output logic [ADDR_W-1:0] i_araddr,
  output logic [7:0]        i_arlen,
  output logic              i_rready,
  output logic              fbuf_we,
  output logic [IDX_W-1:0]  fbuf_idx,
  output logic              fbuf_clear,
  output logic              rbuf_we,
  output logic              data_from_mem_sel,
  output logic [WAYS-1:0]   mem_we,
  output logic [WAYS-1:0]   tagv_we,
  output logic              lru_update,
  output logic              miss_lru_update,
  output logic [WAY_W-1:0]  miss_lru_way,
  output logic              refill_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MISS_A = 3'd2,
    MISS_D = 3'd3,
    DRAIN  = 3'd4,
    REFILL = 3'd5
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  araddr_reg;
  logic [WAY_W-1:0]   way_reg;
  logic [IDX_W-1:0]   cnt_reg;
  logic               unc_reg;
  logic               take_unc;
  logic               latch_miss;
  logic               beat_acc;
  logic               cnt_at_last;
  logic [WAYS-1:0]    way_onehot;

`ifdef ICACHE_UNCACHED_EN
  assign take_unc = uncached;
`else
  assign take_unc = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_onehot
      assign way_onehot[gi] = (way_reg == WAY_W'(gi));
    end
  endgenerate

  // An uncached fetch is a single beat, so its last beat is index 0.
  assign cnt_at_last = unc_reg ? (cnt_reg == '0) : (cnt_reg == IDX_W'(LINE_WORDS - 1));
  assign i_araddr    = araddr_reg;
  assign i_arlen     = unc_reg ? 8'd0 : 8'(LINE_WORDS - 1);
  assign fbuf_idx    = unc_reg ? araddr_reg[OFS_W-1:2] : cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      araddr_reg <= '0;
      way_reg    <= '0;
      cnt_reg    <= '0;
      unc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch_miss) begin
        araddr_reg <= take_unc ? {addr[ADDR_W-1:2], 2'b00}
                               : {addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        way_reg    <= victim_way;
        cnt_reg    <= '0;
        unc_reg    <= take_unc;
      end else if (beat_acc) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next        = IDLE;
    rready            = 1'b0;
    i_arvalid         = 1'b0;
    i_rready          = 1'b0;
    fbuf_we           = 1'b0;
    fbuf_clear        = 1'b0;
    rbuf_we           = 1'b0;
    data_from_mem_sel = 1'b1;
    mem_we            = '0;
    tagv_we           = '0;
    lru_update        = 1'b0;
    miss_lru_update   = 1'b0;
    miss_lru_way      = '0;
    refill_err        = 1'b0;
    latch_miss        = 1'b0;
    beat_acc          = 1'b0;
    case (state_reg)
      IDLE: begin
        rready     = 1'b1;
        rbuf_we    = 1'b1;
        fbuf_clear = 1'b1;
        state_next = rvalid ? LOOKUP : IDLE;
      end
      LOOKUP: begin
        fbuf_clear = 1'b1;
        // A multi-hot vector is still treated as a hit.
        if ((|hit) && !take_unc) begin
          rready            = 1'b1;
          rbuf_we           = 1'b1;
          lru_update        = 1'b1;
          data_from_mem_sel = 1'b0;
          state_next        = rvalid ? LOOKUP : IDLE;
        end else begin
          latch_miss = 1'b1;
          state_next = MISS_A;
        end
      end
      MISS_A: begin
        i_arvalid  = 1'b1;
        state_next = i_arready ? MISS_D : MISS_A;
      end
      MISS_D: begin
        i_rready   = 1'b1;
        state_next = MISS_D;
        if (i_rvalid) begin
          fbuf_we  = 1'b1;
          beat_acc = 1'b1;
          if (i_rlast && cnt_at_last) begin
            state_next = unc_reg ? IDLE : REFILL;
          end else if (i_rlast) begin
            refill_err = 1'b1;
            state_next = IDLE;
          end else if (cnt_at_last) begin
            refill_err = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        i_rready   = 1'b1;
        state_next = (i_rvalid && i_rlast) ? IDLE : DRAIN;
      end
      REFILL: begin
        mem_we          = way_onehot;
        tagv_we         = way_onehot;
        miss_lru_update = 1'b1;
        miss_lru_way    = way_reg;
        state_next      = IDLE;
      end
      default: begin
        rready     = 1'b1;
        rbuf_we    = 1'b1;
        fbuf_clear = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule
